// File: rtl/mult_sum_fixp_pkg.sv
// rtl/mult_sum_fixp_pkg.sv - width helpers and saturation limits for the fixed-point dot-product engine
//
// Contents:
//   prod_width(bitw)     : exact width of one bitw x bitw signed product
//   sum_width(bitw, dim) : exact width of the sum of dim such products
//   sat_max(bitw)        : largest bitw-bit two's-complement value, 2^(bitw-1)-1
//   sat_min(bitw)        : smallest bitw-bit two's-complement value, -2^(bitw-1)
//
// The limits are returned 128 bits wide so that callers can size-cast them
// into any accumulator width without losing the sign.

package mult_sum_fixp_pkg;

    function automatic int prod_width(input int bitw);
        return 2 * bitw;
    endfunction

    function automatic int sum_width(input int bitw, input int dim);
        return 2 * bitw + $clog2(dim);
    endfunction

    function automatic logic signed [127:0] sat_max(input int bitw);
        return (128'sd1 <<< (bitw - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int bitw);
        return -(128'sd1 <<< (bitw - 1));
    endfunction

endpackage

// File: rtl/fixp_rescale_sat.sv
// rtl/fixp_rescale_sat.sv - combinational rescale-by-fracw and saturate-to-bitw stage
//
// Parameters:
//   in_w  : width of the exact signed accumulator
//   bitw  : output width
//   fracw : number of fractional bits dropped by the rescale
// Ports:
//   sum_in : exact signed sum of products (Q with 2*fracw fractional bits)
//   out    : rescaled, saturated result (Q with fracw fractional bits)
//   ovf    : high when out was clamped to a limit

module fixp_rescale_sat
    import mult_sum_fixp_pkg::*;
#(
    parameter int in_w  = 33,
    parameter int bitw  = 16,
    parameter int fracw = 8
) (
    input  logic signed [in_w-1:0] sum_in,
    output logic        [bitw-1:0] out,
    output logic                   ovf
);

    localparam logic signed [in_w-1:0] LIM_HI = in_w'(sat_max(bitw));
    localparam logic signed [in_w-1:0] LIM_LO = in_w'(sat_min(bitw));

    // Arithmetic shift floors toward negative infinity; no rounding is applied.
    logic signed [in_w-1:0] scaled;
    assign scaled = sum_in >>> fracw;

    always_comb begin
        out = scaled[bitw-1:0];
        ovf = 1'b0;
        if (scaled > LIM_HI) begin
            out = LIM_HI[bitw-1:0];
            ovf = 1'b1;
        end else if (scaled < LIM_LO) begin
            out = LIM_LO[bitw-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/mult_sum_fixp.sv
// rtl/mult_sum_fixp.sv - two-stage pipelined signed fixed-point dot product with saturation
//
// Parameters:
//   dim   : number of vector elements
//   bitw  : element and result width
//   fracw : fractional bits of the Q format
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, flushes the pipeline
//   in_valid  : x/weights are valid this cycle
//   x         : signed activations
//   weights   : signed weights
//   out_valid : out carries a new result this cycle
//   out       : signed dot product, held between valid results
//   ovf       : saturation flag for the result on out

module mult_sum_fixp
    import mult_sum_fixp_pkg::*;
#(
    parameter int dim   = 2,
    parameter int bitw  = 16,
    parameter int fracw = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [bitw-1:0] x       [0:dim-1],
    input  logic [bitw-1:0] weights [0:dim-1],
    output logic            out_valid,
    output logic [bitw-1:0] out,
    output logic            ovf
);

    localparam int PW = prod_width(bitw);
    localparam int SW = sum_width(bitw, dim);

    logic signed [PW-1:0] prod [0:dim-1];
    logic                 prod_valid;

    // Stage 1: exact products. Product registers only load on valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_valid <= 1'b0;
            for (int i = 0; i < dim; i++) begin
                prod[i] <= '0;
            end
        end else begin
            prod_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < dim; i++) begin
                    prod[i] <= PW'($signed(x[i])) * PW'($signed(weights[i]));
                end
            end
        end
    end

    // Exact accumulation; the extra clog2(dim) bits make any order safe.
    logic signed [SW-1:0] sum;
    always_comb begin
        sum = '0;
        for (int i = 0; i < dim; i++) begin
            sum = sum + SW'(prod[i]);
        end
    end

    logic [bitw-1:0] res_out;
    logic            res_ovf;

    fixp_rescale_sat #(
        .in_w  (SW),
        .bitw  (bitw),
        .fracw (fracw)
    ) u_rescale (
        .sum_in (sum),
        .out    (res_out),
        .ovf    (res_ovf)
    );

    // Stage 2: out/ovf hold their last valid result across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= prod_valid;
            if (prod_valid) begin
                out <= res_out;
                ovf <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mult_sum_fixp.sv
// tb/tb_mult_sum_fixp.sv - self-checking bench for mult_sum_fixp with directed and random samples

module tb_mult_sum_fixp;

    localparam int DIM = 2;
    localparam int BW  = 16;
    localparam int FW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [BW-1:0] x       [0:DIM-1];
    logic [BW-1:0] weights [0:DIM-1];
    logic          out_valid;
    logic [BW-1:0] out;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_sum_fixp #(.dim(DIM), .bitw(BW), .fracw(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .weights   (weights),
        .out_valid (out_valid),
        .out       (out),
        .ovf       (ovf)
    );

    typedef struct {
        logic          v;
        logic [BW-1:0] o;
        logic          ov;
    } ent_t;

    ent_t          pend [$];
    logic          exp_v;
    logic [BW-1:0] held_o;
    logic          held_ov;

    // Reference: plain integer dot product, floor division by 2^FW, clamp.
    function automatic ent_t model(input logic v);
        ent_t   e;
        longint s = 0;
        longint sc;
        longint hi = (64'sd1 <<< (BW - 1)) - 1;
        longint lo = -(64'sd1 <<< (BW - 1));
        for (int i = 0; i < DIM; i++) begin
            s += longint'($signed(x[i])) * longint'($signed(weights[i]));
        end
        sc   = s >>> FW;
        e.v  = v;
        e.ov = 1'b0;
        if (sc > hi) begin
            e.o  = BW'(hi);
            e.ov = 1'b1;
        end else if (sc < lo) begin
            e.o  = BW'(lo);
            e.ov = 1'b1;
        end else begin
            e.o = BW'(sc);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // One clock: model advances a one-deep delay line, then DUT is compared.
    task automatic tick(input logic r, input logic v);
        ent_t e;
        ent_t f;
        rst      = r;
        in_valid = v;
        e        = model(v);
        @(posedge clk);
        if (r) begin
            pend.delete();
            pend.push_back('{1'b0, '0, 1'b0});
            exp_v   = 1'b0;
            held_o  = '0;
            held_ov = 1'b0;
        end else begin
            pend.push_back(e);
            f     = pend.pop_front();
            exp_v = f.v;
            if (f.v) begin
                held_o  = f.o;
                held_ov = f.ov;
            end
        end
        #1;
        chk("out_valid", BW'(out_valid), BW'(exp_v));
        chk("out", out, held_o);
        chk("ovf", BW'(ovf), BW'(held_ov));
    endtask

    task automatic set_vec(input logic [BW-1:0] x0, input logic [BW-1:0] x1,
                           input logic [BW-1:0] w0, input logic [BW-1:0] w1);
        x[0] = x0; x[1] = x1; weights[0] = w0; weights[1] = w1;
    endtask

    function automatic logic [BW-1:0] rnd_val();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r[BW-1:0];
            1:       return {{5{r[10]}}, r[10:0]};
            2:       return {{9{r[6]}}, r[6:0]};
            default: return ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        endcase
    endfunction

    initial begin
        set_vec('0, '0, '0, '0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("reset_out", out, 16'h0000);
        chk("reset_valid", BW'(out_valid), 16'h0000);

        // Back-to-back samples with weights 2.0 and 1.25.
        set_vec(16'h0500, 16'hFC00, 16'h0200, 16'h0140); tick(1'b0, 1'b1);
        set_vec(16'hFF80, 16'h0880, 16'h0200, 16'h0140); tick(1'b0, 1'b1);
        chk("dir_5p0", out, 16'h0500);
        set_vec('0, '0, '0, '0); tick(1'b0, 1'b0);
        chk("dir_9p625", out, 16'h09A0);
        tick(1'b0, 1'b0);
        chk("idle_hold", out, 16'h09A0);

        set_vec(16'h0500, 16'hFC00, 16'hFFE0, 16'h0700); tick(1'b0, 1'b1);
        set_vec(16'hFF80, 16'h0880, 16'hFFE0, 16'h0700); tick(1'b0, 1'b1);
        chk("dir_m28p625", out, 16'hE360);
        tick(1'b0, 1'b0);
        chk("dir_59p5625", out, 16'h3B90);

        set_vec(16'h0001, 16'h0000, 16'h0001, 16'h0000); tick(1'b0, 1'b1);
        set_vec(16'h0001, 16'h0000, 16'hFFFF, 16'h0000); tick(1'b0, 1'b1);
        chk("trunc_pos", out, 16'h0000);
        set_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF); tick(1'b0, 1'b1);
        chk("trunc_floor", out, 16'hFFFF);
        set_vec(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000); tick(1'b0, 1'b1);
        chk("sat_hi", out, 16'h7FFF);
        chk("sat_hi_ovf", BW'(ovf), 16'h0001);
        tick(1'b0, 1'b0);
        chk("sat_lo", out, 16'h8000);
        chk("sat_lo_ovf", BW'(ovf), 16'h0001);

        // Reset with two samples in flight: neither may emerge.
        set_vec(16'h0500, 16'hFC00, 16'h0200, 16'h0140); tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        chk("rst_flush_out", out, 16'h0000);
        set_vec('0, '0, '0, '0);
        tick(1'b0, 1'b0);
        chk("rst_no_stale", BW'(out_valid), 16'h0000);
        tick(1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            set_vec(rnd_val(), rnd_val(), rnd_val(), rnd_val());
            tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0));
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mult_sum_fixp.md
Name: mult_sum_fixp

Overview:
- Pipelined signed fixed-point dot-product engine: out = sum over i of x[i]*weights[i], in Q(bitw-fracw).(fracw) two's-complement format.
- Serves as the arithmetic datapath of a single neuron. The wrapper holds the weights stable and feeds activation vectors.
- Full-precision accumulation, then rescaling by fracw, then saturation to bitw bits.

Parameters:
- dim, 2, number of vector elements (>=1)
- bitw, 16, total bit width of every input element and of out
- fracw, 8, number of fractional bits (0 <= fracw < bitw)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  x/weights sample is valid this cycle
- x  input  unpacked array [0:dim-1] of bitw  signed activations
- weights  input  unpacked array [0:dim-1] of bitw  signed weights
- out_valid  output  1  out holds a new result
- out  output  bitw  signed dot product, same Q format as inputs
- ovf  output  1  saturation occurred for the result currently on out

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset: when rst is high at a clk edge, the following are cleared to 0 on that edge: out, ovf, out_valid, and all internal pipeline registers and valids.
- Reset mid-operation discards any in-flight samples. No result emerges for them.
- Stage 1 (registered on the edge where in_valid=1):
  - each product p[i] = signed(x[i]) * signed(weights[i]), exact, 2*bitw bits
  - stage-1 valid = in_valid
- Stage 2 (registered):
  - sum = signed sum of all p[i], width 2*bitw + clog2(dim), with no intermediate truncation
  - scaled = sum arithmetically shifted right by fracw. This is truncation toward negative infinity; no rounding.
  - if scaled > 2^(bitw-1)-1: out = 2^(bitw-1)-1 and ovf = 1
  - if scaled < -2^(bitw-1): out = -2^(bitw-1) and ovf = 1
  - otherwise: out = low bitw bits of scaled and ovf = 0
  - out_valid = stage-1 valid
- Latency: exactly 2 clk cycles from the in_valid sample edge to out_valid=1 with the result.
- Throughput: one sample per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Idle cycles: when in_valid=0, the pipeline still advances. out_valid drops to 0, but out and ovf hold their last valid result; they are updated only when a valid sample reaches stage 2.
- Input stability: inputs are sampled only at the clock edge. No handshake backpressure; the consumer must accept a result whenever out_valid=1.
- dim=1: degenerates to a single rescaled, saturated multiply.
- Addition order is irrelevant because the accumulator is exact; an adder tree or a linear chain is acceptable.

Decomposition:
- Package mult_sum_fixp_pkg:
  - localparams/functions for product width (2*bitw) and sum width (2*bitw + clog2(dim))
  - saturation limits MAX = 2^(bitw-1)-1 and MIN = -2^(bitw-1)
- One sub-module, fixp_rescale_sat:
  - input: wide signed sum
  - outputs: out (bitw) and ovf
  - function: performs the shift by fracw and the saturation combinationally
  - parameterised by input width, bitw and fracw

Test Plan (defaults dim=2, bitw=16, fracw=8):
- weights=[0x0200 (2.0), 0x0140 (1.25)], x=[0x0500 (5.0), 0xFC00 (-4.0)], one in_valid pulse -> 2 cycles later out_valid=1, out=0x0500 (5.0), ovf=0.
- Same weights, x=[0xFF80 (-0.5), 0x0880 (8.5)] issued on the cycle immediately after the first sample -> next cycle out=0x09A0 (9.625), proving throughput of 1/cycle.
- weights=[0xFFE0 (-0.125), 0x0700 (7.0)]:
  - x=[0x0500, 0xFC00] -> out=0xE360 (-28.625)
  - then x=[0xFF80, 0x0880] -> out=0x3B90 (59.5625)
- Truncation:
  - weights=[0x0001, 0], x=[0x0001, 0] -> out=0x0000
  - weights=[0xFFFF, 0], x=[0x0001, 0] -> out=0xFFFF (floor, not toward zero)
- Saturation:
  - weights=[0x7FFF, 0x7FFF], x=[0x7FFF, 0x7FFF] -> out=0x7FFF, ovf=1
  - weights=[0x8000, 0x8000], x=[0x7FFF, 0x7FFF] -> out=0x8000, ovf=1
- Reset: assert rst for 1 cycle while two samples are in flight -> out=0, ovf=0, out_valid=0 on the next edge, and no stale result emerges afterwards.
